mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter and sequencer for the single-port memory shared by instruction fetch
// and data access; grants one requester at a time and returns a one-cycle ack.
module mem_port_arbiter #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          sel,
  output logic          busy
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_LAT = CW'(LAT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          drop;
  logic          drop_nxt;
  logic          grant_d;
  logic          grant_i;
  logic          last_beat;

  logic          if_ack_nxt;
  logic [DW-1:0] if_rdata_nxt;
  logic          d_ack_nxt;
  logic [DW-1:0] d_rdata_nxt;
  logic          mem_en_nxt;
  logic          mem_we_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [DW-1:0] mem_wdata_nxt;
  logic          sel_nxt;
  logic          busy_nxt;

  // MEM outranks IF; a requester being acked this cycle is not re-granted
  assign grant_d   = (state == ST_IDLE) && d_req && !d_ack;
  assign grant_i   = (state == ST_IDLE) && !grant_d && if_req && !if_flush && !if_ack;
  assign last_beat = (state == ST_WAIT) && (cnt == CW'(1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (grant_d || grant_i) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (last_beat) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and internal counters
  always_comb begin
    if_ack_nxt    = 1'b0;
    d_ack_nxt     = 1'b0;
    mem_en_nxt    = 1'b0;
    if_rdata_nxt  = if_rdata;
    d_rdata_nxt   = d_rdata;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    sel_nxt       = sel;
    cnt_nxt       = cnt;
    drop_nxt      = drop;
    busy_nxt      = (state_nxt != ST_IDLE);
    case (state)
      ST_IDLE: begin
        drop_nxt = 1'b0;
        if (grant_d) begin
          sel_nxt       = 1'b1;
          mem_en_nxt    = 1'b1;
          mem_we_nxt    = d_we;
          mem_addr_nxt  = d_addr;
          mem_wdata_nxt = d_wdata;
        end else if (grant_i) begin
          sel_nxt      = 1'b0;
          mem_en_nxt   = 1'b1;
          mem_we_nxt   = 1'b0;
          mem_addr_nxt = if_addr;
        end
      end
      ST_ISSUE: begin
        cnt_nxt = CNT_LAT;
        if (!sel && if_flush) drop_nxt = 1'b1;
      end
      ST_WAIT: begin
        cnt_nxt = cnt - CW'(1);
        if (!sel && if_flush) drop_nxt = 1'b1;
        if (last_beat) begin
          drop_nxt = 1'b0;
          if (sel) begin
            d_ack_nxt = 1'b1;
            if (!mem_we) d_rdata_nxt = mem_rdata;
          end else if (!drop && !if_flush) begin
            // a redirect seen at any point of the fetch discards its data
            if_ack_nxt   = 1'b1;
            if_rdata_nxt = mem_rdata;
          end
        end
      end
      default: begin
        cnt_nxt  = '0;
        drop_nxt = 1'b0;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_ack    <= 1'b0;
      if_rdata  <= '0;
      d_ack     <= 1'b0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      sel       <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
      drop      <= 1'b0;
    end else begin
      if_ack    <= if_ack_nxt;
      if_rdata  <= if_rdata_nxt;
      d_ack     <= d_ack_nxt;
      d_rdata   <= d_rdata_nxt;
      mem_en    <= mem_en_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      sel       <= sel_nxt;
      busy      <= busy_nxt;
      cnt       <= cnt_nxt;
      drop      <= drop_nxt;
    end
  end

endmodule
